hex_word_tx: RTL



---
 rtl/hex_word_tx_pkg.sv | 28 ++
 rtl/hex_word_tx.sv | 83 ++++++++
 2 files changed

// File: rtl/hex_word_tx_pkg.sv
// Shared definitions for the ASCII text emitters feeding tx_pipe:
// the printer state type, ASCII constants and a nibble-to-character helper.
package hex_word_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PFX0,
        PFX1,
        DIGITS,
        NL
    } state_e;

    localparam logic [7:0] ASCII_0    = 8'h30;
    localparam logic [7:0] ASCII_X    = 8'h78;
    localparam logic [7:0] ASCII_A_LC = 8'h61;
    localparam logic [7:0] ASCII_NL   = 8'h0A;

    // Lowercase hex digit character for a 4-bit value.
    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
        logic [7:0] code;
        if (nib < 4'd10)
            code = ASCII_0 + {4'b0000, nib};
        else
            code = ASCII_A_LC + {4'b0000, nib} - 8'd10;
        return code;
    endfunction

endpackage

// File: rtl/hex_word_tx.sv
// Prints a captured WIDTH-bit word as fixed-width lowercase hex text into the
// tx_pipe FIFO, one byte per cycle, stalling whenever the FIFO reports full.
module hex_word_tx
    import hex_word_tx_pkg::*;
#(
    parameter int WIDTH   = 64,
    parameter int PREFIX  = 1,
    parameter int NEWLINE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] value,
    output logic             busy,
    input  logic             full,
    output logic             push_back,
    output logic [7:0]       data_out
);

    localparam int NDIGITS = (WIDTH + 3) / 4;
    localparam int SW      = NDIGITS * 4;
    localparam int CW      = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

    state_e          state_q, state_d;
    logic [SW-1:0]   shift_q, shift_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign push_back = busy && !full;

    // Every non-idle state advances only when its byte is actually pushed.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d              = '0;
                    shift_d[WIDTH-1:0]   = value;
                    cnt_d                = CW'(NDIGITS - 1);
                    state_d              = (PREFIX != 0) ? PFX0 : DIGITS;
                end
            end
            PFX0: if (push_back) state_d = PFX1;
            PFX1: if (push_back) state_d = DIGITS;
            DIGITS: begin
                if (push_back) begin
                    shift_d = shift_q << 4;
                    cnt_d   = cnt_q - 1'b1;
                    if (cnt_q == '0)
                        state_d = (NEWLINE != 0) ? NL : IDLE;
                end
            end
            NL:      if (push_back) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        data_out = 8'h00;
        case (state_q)
            PFX0:    data_out = ASCII_0;
            PFX1:    data_out = ASCII_X;
            DIGITS:  data_out = nibble_to_ascii(shift_q[SW-1 -: 4]);
            NL:      data_out = ASCII_NL;
            default: data_out = 8'h00;
        endcase
    end

endmodule
